// File: rtl/sdram_pingpong_arbiter_pkg.sv
// rtl/sdram_pingpong_arbiter_pkg.sv - shared types and helpers for the SDRAM ping-pong burst arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2
    } state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    // True when the address following a burst lands exactly on the end of a frame.
    function automatic logic frame_wrap(input int unsigned next_addr, input int unsigned frame_words);
        return next_addr == frame_words;
    endfunction

endpackage

// File: rtl/sdram_pingpong_arbiter_if.sv
// rtl/sdram_pingpong_arbiter_if.sv - burst trigger/done handshake between arbiter and SDRAM controller
interface sdram_arb_if #(
    parameter int ADDR_W = 22
);
    import sdram_arb_pkg::*;

    logic              wr_trig;
    logic              rd_trig;
    logic              wr_done;
    logic              rd_done;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_bank;
    logic              rd_bank;

    modport master (
        output wr_trig, rd_trig, wr_addr, rd_addr, wr_bank, rd_bank,
        input  wr_done, rd_done
    );

    modport slave (
        input  wr_trig, rd_trig, wr_addr, rd_addr, wr_bank, rd_bank,
        output wr_done, rd_done
    );

endinterface

// File: rtl/sdram_pingpong_arbiter_addr_gen.sv
// rtl/sdram_pingpong_arbiter_addr_gen.sv - burst address counter with frame wrap and bank select
module sdram_arb_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = 22,
    parameter int BURST       = 256,
    parameter int FRAME_WORDS = 307200,
    parameter bit LOAD_BANK   = 1'b0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              bank_in,
    output logic [ADDR_W-1:0] addr,
    output logic              bank
);

    logic [ADDR_W-1:0] next_addr;
    logic              wrap;

    // Next burst start and whether it closes the frame; compare is against the frame size, not 2^ADDR_W.
    always_comb begin
        next_addr = addr + ADDR_W'(BURST);
        wrap      = frame_wrap(32'(next_addr), FRAME_WORDS);
    end

    // Advance on each finished burst; at frame end restart at 0 and either toggle or load the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            bank <= 1'b0;
        end else if (step) begin
            if (wrap) begin
                addr <= '0;
                bank <= LOAD_BANK ? bank_in : ~bank;
            end else begin
                addr <= next_addr;
            end
        end
    end

endmodule

// File: rtl/sdram_pingpong_arbiter.sv
// rtl/sdram_pingpong_arbiter.sv - round-robin SDRAM burst arbiter with ping-pong frames; optional watchdog via SDRAM_ARB_WDOG_EN
module sdram_pingpong_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW          = 9,
    parameter int BURST       = 256,
    parameter int ADDR_W      = 22,
    parameter int FRAME_WORDS = 307200,
    parameter int TIMEOUT     = 4096
)(
    input  logic          rfifo_wclk,
    input  logic          rst_n,
    input  logic          init_done,
    input  logic [AW-1:0] wfifo_usedw,
    input  logic [AW-1:0] rfifo_usedw,
    sdram_arb_if.master   bus,
    output logic          rfifo_rd_ready,
    output logic          err_timeout
);

    state_e     state;
    grant_e     last_grant;
    logic       frame_valid;
    logic       wreq;
    logic       rreq;
    logic       wr_step;
    logic       rd_step;
    logic       wr_wrap;
    logic       rd_fill_ok;
    logic       wdog_hit;
    logic [AW:0] rfifo_free;

    // Request evaluation and burst-completion strobes; done pulses only count in their own busy state.
    always_comb begin
        rfifo_free = {1'b1, {AW{1'b0}}} - {1'b0, rfifo_usedw};
        wreq       = {1'b0, wfifo_usedw} >= (AW+1)'(BURST);
        rreq       = frame_valid && (rfifo_free > (AW+1)'(BURST));
        rd_fill_ok = {1'b0, rfifo_usedw} >= (AW+1)'(BURST);
        wr_step    = (state == WR_BUSY) && bus.wr_done;
        rd_step    = (state == RD_BUSY) && bus.rd_done;
        wr_wrap    = wr_step && frame_wrap(32'(bus.wr_addr + ADDR_W'(BURST)), FRAME_WORDS);
    end

    // Arbitration FSM: grant in IDLE, one-cycle trig, wait for done (or watchdog) to return.
    always_ff @(posedge rfifo_wclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= GNT_RD;
            bus.wr_trig    <= 1'b0;
            bus.rd_trig    <= 1'b0;
            frame_valid    <= 1'b0;
            rfifo_rd_ready <= 1'b0;
        end else begin
            bus.wr_trig <= 1'b0;
            bus.rd_trig <= 1'b0;
            if (wr_wrap) begin
                frame_valid <= 1'b1;
            end
            if (frame_valid && rd_fill_ok) begin
                rfifo_rd_ready <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (init_done) begin
                        if (wreq && (!rreq || last_grant == GNT_RD)) begin
                            state       <= WR_BUSY;
                            bus.wr_trig <= 1'b1;
                            last_grant  <= GNT_WR;
                        end else if (rreq) begin
                            state       <= RD_BUSY;
                            bus.rd_trig <= 1'b1;
                            last_grant  <= GNT_RD;
                        end
                    end
                end
                WR_BUSY: begin
                    if (bus.wr_done || wdog_hit) begin
                        state <= IDLE;
                    end
                end
                RD_BUSY: begin
                    if (bus.rd_done || wdog_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              err_q;

    assign wdog_hit    = (state != IDLE) && (wdog_cnt == WDOG_W'(TIMEOUT - 1));
    assign err_timeout = err_q;

    // Count busy cycles; expiry abandons the burst without advancing the address so it is retried.
    always_ff @(posedge rfifo_wclk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE || wdog_hit) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (wdog_hit && !wr_step && !rd_step) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    // No watchdog: busy states wait for done indefinitely; the tie-off still references TIMEOUT.
    assign wdog_hit    = 1'b0;
    assign err_timeout = (TIMEOUT < 0);
`endif

    sdram_arb_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST       (BURST),
        .FRAME_WORDS (FRAME_WORDS),
        .LOAD_BANK   (1'b0)
    ) u_wr_addr (
        .clk     (rfifo_wclk),
        .rst_n   (rst_n),
        .step    (wr_step),
        .bank_in (1'b0),
        .addr    (bus.wr_addr),
        .bank    (bus.wr_bank)
    );

    // Read side takes the last completed bank (opposite of the one being written) at each frame wrap.
    sdram_arb_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST       (BURST),
        .FRAME_WORDS (FRAME_WORDS),
        .LOAD_BANK   (1'b1)
    ) u_rd_addr (
        .clk     (rfifo_wclk),
        .rst_n   (rst_n),
        .step    (rd_step),
        .bank_in (~bus.wr_bank),
        .addr    (bus.rd_addr),
        .bank    (bus.rd_bank)
    );

endmodule

// File: tb/tb_sdram_pingpong_arbiter.sv
// tb/tb_sdram_pingpong_arbiter.sv - directed self-checking bench for sdram_pingpong_arbiter
module tb_sdram_pingpong_arbiter;
    import sdram_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    logic [8:0] wfifo_usedw;
    logic [8:0] rfifo_usedw;
    logic       rfifo_rd_ready;
    logic       err_timeout;
    int         total = 0;
    int         bad = 0;

    sdram_arb_if #(.ADDR_W(22)) bus ();

    sdram_pingpong_arbiter #(
        .AW          (9),
        .BURST       (256),
        .ADDR_W      (22),
        .FRAME_WORDS (1024),
        .TIMEOUT     (16)
    ) dut (
        .rfifo_wclk     (clk),
        .rst_n          (rst_n),
        .init_done      (init_done),
        .wfifo_usedw    (wfifo_usedw),
        .rfifo_usedw    (rfifo_usedw),
        .bus            (bus),
        .rfifo_rd_ready (rfifo_rd_ready),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr_burst(input int exp_addr);
        tick();
        check("wr_trig_grant", 32'(bus.wr_trig), 1);
        check("wr_addr_at_trig", 32'(bus.wr_addr), exp_addr);
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        check("wr_trig_after_done", 32'(bus.wr_trig), 0);
    endtask

    task automatic rd_burst(input int exp_addr);
        tick();
        check("rd_trig_grant", 32'(bus.rd_trig), 1);
        check("rd_addr_at_trig", 32'(bus.rd_addr), exp_addr);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        check("rd_trig_after_done", 32'(bus.rd_trig), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        init_done   = 1'b0;
        wfifo_usedw = '0;
        rfifo_usedw = '0;
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        repeat (3) tick();

        check("rst_wr_trig", 32'(bus.wr_trig), 0);
        check("rst_rd_trig", 32'(bus.rd_trig), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_wr_bank", 32'(bus.wr_bank), 0);
        check("rst_rd_bank", 32'(bus.rd_bank), 0);
        check("rst_ready", 32'(rfifo_rd_ready), 0);
        check("rst_err", 32'(err_timeout), 0);

        rst_n = 1'b1;
        tick();
        check("no_grant_before_init", 32'(bus.wr_trig), 0);

        // First write request: trig one cycle after sampling, single-cycle pulse
        init_done   = 1'b1;
        wfifo_usedw = 9'd256;
        rfifo_usedw = 9'd0;
        tick();
        check("first_wr_trig", 32'(bus.wr_trig), 1);
        check("first_rd_trig", 32'(bus.rd_trig), 0);
        check("first_wr_addr", 32'(bus.wr_addr), 0);
        check("first_wr_bank", 32'(bus.wr_bank), 0);
        tick();
        check("wr_trig_one_cycle", 32'(bus.wr_trig), 0);
        check("no_rd_without_frame", 32'(bus.rd_trig), 0);
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        check("wr_addr_256", 32'(bus.wr_addr), 256);
        check("idle_after_done", 32'(dut.state), 32'(IDLE));

        // Remaining bursts of frame 0
        wr_burst(256);
        check("wr_addr_512", 32'(bus.wr_addr), 512);
        wr_burst(512);
        check("wr_addr_768", 32'(bus.wr_addr), 768);
        check("frame_not_valid_yet", 32'(dut.frame_valid), 0);
        wr_burst(768);
        check("wr_addr_wrap", 32'(bus.wr_addr), 0);
        check("wr_bank_toggle", 32'(bus.wr_bank), 1);
        check("frame_valid_set", 32'(dut.frame_valid), 1);

        // Both requests active: R, W, R, W after last grant was W
        tick();
        check("tie_rd_trig", 32'(bus.rd_trig), 1);
        check("tie_no_wr_trig", 32'(bus.wr_trig), 0);
        check("tie_rd_addr", 32'(bus.rd_addr), 0);
        check("tie_rd_bank", 32'(bus.rd_bank), 0);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        check("rd_addr_256", 32'(bus.rd_addr), 256);
        wr_burst(0);
        check("alt_wr_addr_256", 32'(bus.wr_addr), 256);
        rd_burst(256);
        check("rd_addr_512", 32'(bus.rd_addr), 512);
        tick();
        check("alt_wr_trig", 32'(bus.wr_trig), 1);
        check("alt_wr_trig_addr", 32'(bus.wr_addr), 256);

        // Stray rd_done while in WR_BUSY is ignored
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        check("stray_rd_state", 32'(dut.state), 32'(WR_BUSY));
        check("stray_rd_rd_addr", 32'(bus.rd_addr), 512);
        check("stray_rd_wr_addr", 32'(bus.wr_addr), 256);

        // Block both requests; read FIFO at 256 raises ready
        wfifo_usedw = 9'd0;
        rfifo_usedw = 9'd256;
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        check("wr_addr_512_b", 32'(bus.wr_addr), 512);
        check("ready_rise", 32'(rfifo_rd_ready), 1);

        // Stray wr_done in IDLE is ignored
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        check("stray_wr_state", 32'(dut.state), 32'(IDLE));
        check("stray_wr_addr", 32'(bus.wr_addr), 512);
        check("stray_wr_no_trig", 32'(bus.wr_trig | bus.rd_trig), 0);

        // Ready is sticky; empty read FIFO requests a read
        rfifo_usedw = 9'd0;
        tick();
        check("ready_sticky", 32'(rfifo_rd_ready), 1);
        check("rd_trig_empty_fifo", 32'(bus.rd_trig), 1);
        check("rd_trig_addr_512", 32'(bus.rd_addr), 512);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        rd_burst(768);
        check("rd_addr_wrap", 32'(bus.rd_addr), 0);
        check("rd_bank_first_frame", 32'(bus.rd_bank), 0);

        // Second write frame completes into bank 1, leaving wr_bank at 0
        rfifo_usedw = 9'd256;
        wfifo_usedw = 9'd256;
        wr_burst(512);
        wr_burst(768);
        check("wr_addr_wrap2", 32'(bus.wr_addr), 0);
        check("wr_bank_back_0", 32'(bus.wr_bank), 0);

        // Full read frame now picks the newly completed bank 1
        wfifo_usedw = 9'd0;
        rfifo_usedw = 9'd0;
        rd_burst(0);
        rd_burst(256);
        rd_burst(512);
        check("rd_bank_before_wrap", 32'(bus.rd_bank), 0);
        rd_burst(768);
        check("rd_addr_wrap2", 32'(bus.rd_addr), 0);
        check("rd_bank_second_frame", 32'(bus.rd_bank), 1);

        // Write burst with wr_done held low
        rfifo_usedw = 9'd256;
        wfifo_usedw = 9'd256;
        tick();
        check("hang_wr_trig", 32'(bus.wr_trig), 1);
        check("hang_wr_addr", 32'(bus.wr_addr), 0);
`ifdef SDRAM_ARB_WDOG_EN
        repeat (15) tick();
        check("wdog_still_busy", 32'(dut.state), 32'(WR_BUSY));
        check("wdog_err_not_yet", 32'(err_timeout), 0);
        tick();
        check("wdog_idle", 32'(dut.state), 32'(IDLE));
        check("wdog_err_set", 32'(err_timeout), 1);
        tick();
        check("wdog_retry_trig", 32'(bus.wr_trig), 1);
        check("wdog_retry_addr", 32'(bus.wr_addr), 0);
        check("wdog_err_sticky", 32'(err_timeout), 1);
`else
        repeat (40) tick();
        check("nowdog_busy", 32'(dut.state), 32'(WR_BUSY));
        check("nowdog_err", 32'(err_timeout), 0);
        check("nowdog_no_trig", 32'(bus.wr_trig), 0);
`endif

        // Asynchronous reset mid-burst, then a late done
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        init_done = 1'b0;
        #1;
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        check("mid_rst_rd_bank", 32'(bus.rd_bank), 0);
        check("mid_rst_ready", 32'(rfifo_rd_ready), 0);
        check("mid_rst_err", 32'(err_timeout), 0);
        check("mid_rst_frame_valid", 32'(dut.frame_valid), 0);
        tick();
        rst_n       = 1'b1;
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        check("late_done_state", 32'(dut.state), 32'(IDLE));
        check("late_done_wr_addr", 32'(bus.wr_addr), 0);
        check("late_done_wr_bank", 32'(bus.wr_bank), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
